wb_stage: RTL and testbench

- Writeback stage of the five-stage pipeline. It is the producer side of the register-file write port.
- Latches the MEM/WB pipeline fields, then extracts and extends load data and selects the writeback source. Drives writeReg/writeData/RegWrite into the register file.
- Also provides WB→ID bypass hit flags, so ID sees data being written in the same cycle, and counts retired instructions.

---
 rtl/wb_stage.sv | 152 +++++++++++++++
 tb/tb_wb_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: latches the MEM/WB fields, extracts and extends load data,
// selects the writeback source and drives the register-file write port.
// Also provides WB->ID bypass hit flags and a retired-instruction counter.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic [1:0]        in_wb_sel,
  input  logic [REG_AW-1:0] in_write_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc_plus8,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  output logic              RegWrite,
  output logic [REG_AW-1:0] writeReg,
  output logic [DATA_W-1:0] writeData,
  output logic              id_rs_fwd,
  output logic              id_rt_fwd,
  output logic              wb_misalign,
  output logic [31:0]       retire_count
);

  logic              valid_q, valid_d;
  logic              fresh_q, fresh_d;
  logic              reg_write_q, reg_write_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic [REG_AW-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0] pc8_q, pc8_d;
  logic [1:0]        load_size_q, load_size_d;
  logic              load_uns_q, load_uns_d;
  logic [31:0]       retire_count_q, retire_count_d;

  logic              retire;
  logic [DATA_W-1:0] load_data;

  // Little-endian sub-word extraction with zero or sign extension.
  function automatic logic [DATA_W-1:0] extend_load(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        addr,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [15:0] half;
    logic [7:0]  byte_v;
    half   = addr[1] ? word[31:16] : word[15:0];
    byte_v = word[{addr, 3'b000} +: 8];
    case (size)
      2'b01:   return uns ? {{(DATA_W-16){1'b0}}, half}
                          : {{(DATA_W-16){half[15]}}, half};
      2'b10:   return uns ? {{(DATA_W-8){1'b0}}, byte_v}
                          : {{(DATA_W-8){byte_v[7]}}, byte_v};
      default: return word;
    endcase
  endfunction

  // Next WB contents: flush beats stall; a held instruction loses its fresh bit.
  always_comb begin
    valid_d     = valid_q;
    fresh_d     = 1'b0;
    reg_write_d = reg_write_q;
    wb_sel_d    = wb_sel_q;
    write_reg_d = write_reg_q;
    alu_d       = alu_q;
    mem_d       = mem_q;
    pc8_d       = pc8_q;
    load_size_d = load_size_q;
    load_uns_d  = load_uns_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      wb_sel_d    = '0;
      write_reg_d = '0;
      alu_d       = '0;
      mem_d       = '0;
      pc8_d       = '0;
      load_size_d = '0;
      load_uns_d  = 1'b0;
    end else if (!stall) begin
      valid_d     = in_valid;
      fresh_d     = 1'b1;
      reg_write_d = in_reg_write;
      wb_sel_d    = in_wb_sel;
      write_reg_d = in_write_reg;
      alu_d       = in_alu_result;
      mem_d       = in_mem_data;
      pc8_d       = in_pc_plus8;
      load_size_d = in_load_size;
      load_uns_d  = in_load_unsigned;
    end
    retire_count_d = retire ? retire_count_q + 32'd1 : retire_count_q;
  end

  // WB pipeline register and retire counter; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      fresh_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      wb_sel_q       <= '0;
      write_reg_q    <= '0;
      alu_q          <= '0;
      mem_q          <= '0;
      pc8_q          <= '0;
      load_size_q    <= '0;
      load_uns_q     <= 1'b0;
      retire_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      fresh_q        <= fresh_d;
      reg_write_q    <= reg_write_d;
      wb_sel_q       <= wb_sel_d;
      write_reg_q    <= write_reg_d;
      alu_q          <= alu_d;
      mem_q          <= mem_d;
      pc8_q          <= pc8_d;
      load_size_q    <= load_size_d;
      load_uns_q     <= load_uns_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Writeback source mux, misalignment, write enable and bypass flags.
  always_comb begin
    load_data   = extend_load(mem_q, alu_q[1:0], load_size_q, load_uns_q);
    case (wb_sel_q)
      2'b01:   writeData = load_data;
      2'b10:   writeData = pc8_q;
      default: writeData = alu_q;
    endcase
    wb_misalign = valid_q && fresh_q && (wb_sel_q == 2'b01) &&
                  ((((load_size_q == 2'b00) || (load_size_q == 2'b11)) && (alu_q[1:0] != 2'b00)) ||
                   ((load_size_q == 2'b01) && alu_q[0]));
    retire      = valid_q && fresh_q && !wb_misalign;
    RegWrite    = valid_q && fresh_q && reg_write_q && (write_reg_q != '0) && !wb_misalign;
    writeReg    = write_reg_q;
    id_rs_fwd   = RegWrite && (write_reg_q == id_rs);
    id_rt_fwd   = RegWrite && (write_reg_q == id_rt);
    retire_count = retire_count_q;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage against a behavioural model of the WB stage.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        in_valid, in_reg_write, in_load_unsigned;
  logic [1:0]  in_wb_sel, in_load_size;
  logic [4:0]  in_write_reg, id_rs, id_rt;
  logic [31:0] in_alu_result, in_mem_data, in_pc_plus8;
  logic        RegWrite, id_rs_fwd, id_rt_fwd, wb_misalign;
  logic [4:0]  writeReg;
  logic [31:0] writeData, retire_count;

  int errors = 0;
  int checks = 0;

  // model of the instruction currently sitting in WB
  logic        m_valid, m_fresh, m_rw, m_uns;
  logic [1:0]  m_sel, m_size;
  logic [4:0]  m_wr;
  logic [31:0] m_alu, m_mem, m_pc8, m_cnt;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_write_reg(in_write_reg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc_plus8(in_pc_plus8),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .id_rs(id_rs), .id_rt(id_rt),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
    .id_rs_fwd(id_rs_fwd), .id_rt_fwd(id_rt_fwd), .wb_misalign(wb_misalign),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_load();
    logic [31:0] sh;
    logic [15:0] h;
    logic [7:0]  b;
    sh = m_mem >> (8 * m_alu[1:0]);
    b  = sh[7:0];
    h  = (m_alu[1:0] >= 2) ? m_mem[31:16] : m_mem[15:0];
    if (m_size == 2'b10) return m_uns ? {24'd0, b} : 32'($signed(b));
    if (m_size == 2'b01) return m_uns ? {16'd0, h} : 32'($signed(h));
    return m_mem;
  endfunction

  function automatic logic m_mis();
    logic word_ld;
    word_ld = (m_size == 2'b00) || (m_size == 2'b11);
    return m_valid && m_fresh && m_sel == 2'b01 &&
           ((word_ld && m_alu[1:0] != 0) || (m_size == 2'b01 && m_alu[0] == 1'b1));
  endfunction

  function automatic logic [72:0] expv();
    logic        we;
    logic [31:0] wd;
    we = m_valid && m_fresh && m_rw && (m_wr != 0) && !m_mis();
    wd = (m_sel == 2'b01) ? m_load() : (m_sel == 2'b10) ? m_pc8 : m_alu;
    return {we, m_wr, wd, we && (m_wr == id_rs), we && (m_wr == id_rt), m_mis(), m_cnt};
  endfunction

  function automatic logic [72:0] obs();
    return {RegWrite, writeReg, writeData, id_rs_fwd, id_rt_fwd, wb_misalign, retire_count};
  endfunction

  task automatic model_edge();
    logic ret;
    ret = m_valid && m_fresh && !m_mis();
    if (rst) begin
      {m_valid, m_fresh, m_rw, m_uns, m_sel, m_size, m_wr} = '0;
      {m_alu, m_mem, m_pc8, m_cnt} = '0;
    end else begin
      if (ret) m_cnt = m_cnt + 1;
      if (flush) begin
        {m_valid, m_fresh, m_rw, m_uns, m_sel, m_size, m_wr} = '0;
        {m_alu, m_mem, m_pc8} = '0;
      end else if (stall) begin
        m_fresh = 1'b0;
      end else begin
        m_valid = in_valid; m_fresh = 1'b1; m_rw = in_reg_write; m_uns = in_load_unsigned;
        m_sel = in_wb_sel; m_size = in_load_size; m_wr = in_write_reg;
        m_alu = in_alu_result; m_mem = in_mem_data; m_pc8 = in_pc_plus8;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic put(input logic v, input logic rw, input logic [1:0] sel, input logic [4:0] wr,
                     input logic [31:0] alu, input logic [31:0] mem, input logic [1:0] sz,
                     input logic uns);
    in_valid = v; in_reg_write = rw; in_wb_sel = sel; in_write_reg = wr;
    in_alu_result = alu; in_mem_data = mem; in_pc_plus8 = alu + 32'd8;
    in_load_size = sz; in_load_unsigned = uns;
  endtask

  task automatic test_reset();
    put(1'b1, 1'b1, 2'b00, 5'd3, 32'hDEAD_BEEF, 32'h1, 2'b00, 1'b0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    put(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    checks++;
    if (obs() !== 73'd0) begin
      errors++; $display("FAIL reset_outputs: got %h exp %h", obs(), 73'd0);
    end
  endtask

  task automatic test_alu_write();
    put(1'b1, 1'b1, 2'b00, 5'd5, 32'h1234_5678, 32'h0, 2'b00, 1'b0);
    tick();
    checks++;
    if ({RegWrite, writeReg, writeData, retire_count} !== {1'b1, 5'd5, 32'h1234_5678, 32'd0}) begin
      errors++; $display("FAIL alu_write: got we=%b rd=%0d wd=%h cnt=%0d exp we=1 rd=5 wd=12345678 cnt=0",
                         RegWrite, writeReg, writeData, retire_count);
    end
    put(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    tick();
    checks++;
    if (retire_count !== 32'd1) begin
      errors++; $display("FAIL alu_retire: got %0d exp 1", retire_count);
    end
  endtask

  task automatic test_loads();
    logic [1:0]  sz [5] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b00};
    logic        un [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  ad [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
    logic [31:0] ex [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      put(1'b1, 1'b1, 2'b01, 5'd3, {30'h400, ad[i]}, 32'h80FF_7F01, sz[i], un[i]);
      tick();
      checks++;
      if (writeData !== ex[i] || RegWrite !== 1'b1 || obs() !== expv()) begin
        errors++; $display("FAIL load_%0d: got wd=%h we=%b exp wd=%h we=1", i, writeData, RegWrite, ex[i]);
      end
    end
  endtask

  task automatic test_misalign_r0();
    logic [31:0] cb;
    put(1'b1, 1'b1, 2'b01, 5'd6, 32'h0000_1002, 32'h1111_2222, 2'b00, 1'b0);
    tick();
    cb = m_cnt;
    checks++;
    if (wb_misalign !== 1'b1 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL misalign: got mis=%b we=%b exp mis=1 we=0", wb_misalign, RegWrite);
    end
    put(1'b1, 1'b1, 2'b00, 5'd0, 32'h0000_0055, 32'h0, 2'b00, 1'b0);
    tick();
    checks++;
    if (retire_count !== cb || RegWrite !== 1'b0) begin
      errors++; $display("FAIL misalign_count: got cnt=%0d we=%b exp cnt=%0d we=0", retire_count, RegWrite, cb);
    end
    put(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    tick();
    checks++;
    if (retire_count !== cb + 32'd1) begin
      errors++; $display("FAIL r0_count: got %0d exp %0d", retire_count, cb + 32'd1);
    end
  endtask

  task automatic test_stall();
    logic [31:0] cb;
    put(1'b1, 1'b1, 2'b00, 5'd7, 32'h0000_0777, 32'h0, 2'b00, 1'b0);
    tick();
    cb = m_cnt;
    checks++;
    if (RegWrite !== 1'b1 || writeReg !== 5'd7) begin
      errors++; $display("FAIL stall_first: got we=%b rd=%0d exp we=1 rd=7", RegWrite, writeReg);
    end
    stall = 1'b1;
    put(1'b1, 1'b1, 2'b00, 5'd8, 32'h0000_0888, 32'h0, 2'b00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (RegWrite !== 1'b0 || writeReg !== 5'd7 || writeData !== 32'h777 || retire_count !== cb + 32'd1) begin
        errors++; $display("FAIL stall_hold_%0d: got we=%b rd=%0d cnt=%0d exp we=0 rd=7 cnt=%0d",
                           i, RegWrite, writeReg, retire_count, cb + 32'd1);
      end
    end
    stall = 1'b0;
    put(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    tick();
    checks++;
    if (retire_count !== cb + 32'd1) begin
      errors++; $display("FAIL stall_count: got %0d exp %0d", retire_count, cb + 32'd1);
    end
  endtask

  task automatic test_flush_stall_rst();
    logic [31:0] cb;
    put(1'b1, 1'b1, 2'b00, 5'd10, 32'h0000_00AA, 32'h0, 2'b00, 1'b0);
    flush = 1'b1; stall = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    cb = m_cnt;
    checks++;
    if (RegWrite !== 1'b0 || writeData !== 32'd0) begin
      errors++; $display("FAIL flush_stall: got we=%b wd=%h exp we=0 wd=0", RegWrite, writeData);
    end
    put(1'b1, 1'b1, 2'b00, 5'd4, 32'h0000_0444, 32'h0, 2'b00, 1'b0);
    tick();
    checks++;
    if (retire_count !== cb) begin
      errors++; $display("FAIL flush_count: got %0d exp %0d", retire_count, cb);
    end
    stall = 1'b1; rst = 1'b1;
    tick();
    stall = 1'b0; rst = 1'b0;
    checks++;
    if (obs() !== 73'd0) begin
      errors++; $display("FAIL rst_in_stall: got %h exp 0", obs());
    end
  endtask

  task automatic test_bypass_wrap();
    put(1'b1, 1'b1, 2'b00, 5'd9, 32'h0000_0999, 32'h0, 2'b00, 1'b0);
    id_rs = 5'd9; id_rt = 5'd9;
    tick();
    checks++;
    if (id_rs_fwd !== 1'b1 || id_rt_fwd !== 1'b1) begin
      errors++; $display("FAIL bypass_hit: got rs=%b rt=%b exp 1 1", id_rs_fwd, id_rt_fwd);
    end
    put(1'b1, 1'b1, 2'b00, 5'd0, 32'h0000_0123, 32'h0, 2'b00, 1'b0);
    id_rs = 5'd0; id_rt = 5'd0;
    tick();
    checks++;
    if (id_rs_fwd !== 1'b0 || id_rt_fwd !== 1'b0) begin
      errors++; $display("FAIL bypass_r0: got rs=%b rt=%b exp 0 0", id_rs_fwd, id_rt_fwd);
    end
    put(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    tick(); tick();
    #3;
    force dut.retire_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_count_q;
    m_cnt = 32'hFFFF_FFFF;
    put(1'b1, 1'b0, 2'b00, 5'd2, 32'h0000_0002, 32'h0, 2'b00, 1'b0);
    tick();
    checks++;
    if (retire_count !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_pre: got %h exp ffffffff", retire_count);
    end
    put(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    tick();
    checks++;
    if (retire_count !== 32'd0) begin
      errors++; $display("FAIL wrap: got %h exp 0", retire_count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      put(1'($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom), 5'($urandom_range(0, 7)),
          $urandom, $urandom, 2'($urandom), 1'($urandom));
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 9) == 0);
      id_rs = 5'($urandom_range(0, 7));
      id_rt = 5'($urandom_range(0, 7));
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL random_%0d: got %h exp %h", i, obs(), expv());
      end
    end
    stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; id_rs = '0; id_rt = '0;
    put(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 2'b00, 1'b0);
    {m_valid, m_fresh, m_rw, m_uns, m_sel, m_size, m_wr} = '0;
    {m_alu, m_mem, m_pc8, m_cnt} = '0;
    test_reset();
    test_alu_write();
    test_loads();
    test_misalign_r0();
    test_stall();
    test_flush_stall_rst();
    test_bypass_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
